branch_predictor: RTL and testbench

//   Dynamic branch predictor for the pipelined MIPS core: direct-mapped branch target buffer (BTB)

---
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, zero-latency lookup for IF,
// training from EXE, and saturating lookup/mispredict statistics.
module branch_predictor #(
    parameter int         DATA_W   = 32,
    parameter int         IDX_W    = 6,
    parameter int         STAT_W   = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] lookup_pc,
    input  logic              lookup_valid,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_pc,
    input  logic              upd_en,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [DATA_W-1:0] upd_target,
    input  logic              upd_mispred,
    input  logic              flush_tbl,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = DATA_W - IDX_W - 2;

    logic              valid  [ENTRIES];
    logic [TAG_W-1:0]  tag    [ENTRIES];
    logic [DATA_W-1:0] target [ENTRIES];
    logic [1:0]        ctr    [ENTRIES];

    logic [IDX_W-1:0]  lookup_idx, upd_idx;
    logic [TAG_W-1:0]  lookup_tag, upd_tag;
    logic              lookup_hit, upd_hit;
    logic              unused_bits;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
        return (&s) ? s : s + STAT_W'(1);
    endfunction

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign lookup_tag = lookup_pc[DATA_W-1:IDX_W+2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign upd_tag    = upd_pc[DATA_W-1:IDX_W+2];
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
    assign lookup_hit = valid[lookup_idx] && (tag[lookup_idx] == lookup_tag);
    assign upd_hit    = valid[upd_idx] && (tag[upd_idx] == upd_tag);
    assign pred_taken = lookup_hit && ctr[lookup_idx][1];
    assign pred_pc    = pred_taken ? target[lookup_idx] : lookup_pc + DATA_W'(4);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= CTR_INIT;
            end
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else if (enable) begin
            // Flush wins over a coincident update; stats keep counting either way.
            if (flush_tbl) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid[i] <= 1'b0;
                    ctr[i]   <= CTR_INIT;
                end
            end else if (upd_en) begin
                if (upd_hit) begin
                    if (upd_taken) begin
                        ctr[upd_idx]    <= ctr_inc(ctr[upd_idx]);
                        target[upd_idx] <= upd_target;
                    end else begin
                        ctr[upd_idx]    <= ctr_dec(ctr[upd_idx]);
                    end
                end else if (upd_taken) begin
                    valid[upd_idx]  <= 1'b1;
                    tag[upd_idx]    <= upd_tag;
                    target[upd_idx] <= upd_target;
                    ctr[upd_idx]    <= 2'b10;
                end
            end
            if (lookup_valid)
                stat_lookups <= stat_inc(stat_lookups);
            if (upd_en && upd_mispred)
                stat_mispred <= stat_inc(stat_mispred);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: table-driven training/lookup vectors plus
// hand-written sequences for same-cycle update, flush, enable, stats saturation and reset.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic [31:0] lookup_pc;
    logic        lookup_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic        flush_tbl;
    logic [3:0]  stat_lookups;
    logic [3:0]  stat_mispred;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(.DATA_W(32), .IDX_W(6), .STAT_W(4), .CTR_INIT(2'b01)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .lookup_pc(lookup_pc), .lookup_valid(lookup_valid),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispred(upd_mispred),
        .flush_tbl(flush_tbl),
        .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        upd;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] lpc;
        logic        etk;
        logic [31:0] epc;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_pred(input string name, input logic etk, input logic [31:0] epc);
        check({name, "_taken"}, {31'b0, pred_taken}, {31'b0, etk});
        check({name, "_pc"}, pred_pc, epc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0; enable = 1'b1; lookup_pc = 32'h40; lookup_valid = 1'b0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_mispred = 1'b0; flush_tbl = 1'b0;

        // Training history at idx of 0x40; 0x140 aliases onto it.
        vt[0]  = '{1'b0, 32'h000, 1'b0, 32'h000, 32'h40,       1'b0, 32'h44};
        vt[1]  = '{1'b1, 32'h040, 1'b1, 32'h100, 32'h40,       1'b1, 32'h100};
        vt[2]  = '{1'b1, 32'h040, 1'b0, 32'h000, 32'h40,       1'b0, 32'h44};
        vt[3]  = '{1'b1, 32'h040, 1'b0, 32'h000, 32'h40,       1'b0, 32'h44};
        vt[4]  = '{1'b1, 32'h040, 1'b0, 32'h000, 32'h40,       1'b0, 32'h44};
        vt[5]  = '{1'b1, 32'h040, 1'b1, 32'h104, 32'h40,       1'b0, 32'h44};
        vt[6]  = '{1'b1, 32'h040, 1'b1, 32'h108, 32'h40,       1'b1, 32'h108};
        vt[7]  = '{1'b1, 32'h040, 1'b1, 32'h108, 32'h40,       1'b1, 32'h108};
        vt[8]  = '{1'b1, 32'h040, 1'b1, 32'h108, 32'h40,       1'b1, 32'h108};
        vt[9]  = '{1'b1, 32'h040, 1'b0, 32'h999, 32'h40,       1'b1, 32'h108};
        vt[10] = '{1'b1, 32'h040, 1'b0, 32'h000, 32'h40,       1'b0, 32'h44};
        vt[11] = '{1'b1, 32'h040, 1'b1, 32'h100, 32'h40,       1'b1, 32'h100};
        vt[12] = '{1'b1, 32'h140, 1'b1, 32'h200, 32'h40,       1'b0, 32'h44};
        vt[13] = '{1'b0, 32'h000, 1'b0, 32'h000, 32'h140,      1'b1, 32'h200};
        vt[14] = '{1'b1, 32'h040, 1'b0, 32'h000, 32'h140,      1'b1, 32'h200};
        vt[15] = '{1'b0, 32'h000, 1'b0, 32'h000, 32'hFFFFFFFC, 1'b0, 32'h0};

        #1;
        check_pred("reset_async", 1'b0, 32'h44);
        #12;
        arst_n = 1'b1;
        tick();
        check_pred("post_reset", 1'b0, 32'h44);
        check("post_reset_lookups", {28'b0, stat_lookups}, 32'd0);
        check("post_reset_mispred", {28'b0, stat_mispred}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            upd_en = vt[i].upd; upd_pc = vt[i].upc; upd_taken = vt[i].tk;
            upd_target = vt[i].tgt;
            tick();
            upd_en = 1'b0;
            lookup_pc = vt[i].lpc;
            #1;
            check_pred($sformatf("vec%0d", i), vt[i].etk, vt[i].epc);
        end

        // Same-cycle lookup and update of 0x80: old prediction now, new one after the edge.
        upd_en = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h500;
        tick();
        upd_pc = 32'h80; upd_taken = 1'b0; lookup_pc = 32'h80;
        #1;
        check_pred("same_cycle_old", 1'b1, 32'h500);
        tick();
        upd_en = 1'b0;
        #1;
        check_pred("same_cycle_new", 1'b0, 32'h84);

        // Disabled update leaves the table frozen (0x140 still hits).
        enable = 1'b0; upd_en = 1'b1; upd_pc = 32'h140; upd_taken = 1'b0;
        lookup_pc = 32'h140;
        tick(); tick();
        upd_en = 1'b0; enable = 1'b1;
        #1;
        check_pred("enable_low_frozen", 1'b1, 32'h200);

        // Flush with a coincident taken update to 0x80: update dropped.
        flush_tbl = 1'b1; upd_en = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1;
        upd_target = 32'h600;
        tick();
        flush_tbl = 1'b0; upd_en = 1'b0;
        lookup_pc = 32'h80;
        #1;
        check_pred("flush_0x80", 1'b0, 32'h84);
        lookup_pc = 32'h140;
        #1;
        check_pred("flush_0x140", 1'b0, 32'h144);
        check("flush_stats_lookups", {28'b0, stat_lookups}, 32'd0);

        // enable low: lookup_valid and mispredicts are not counted.
        enable = 1'b0; lookup_valid = 1'b1; upd_en = 1'b1; upd_mispred = 1'b1;
        upd_pc = 32'h300; upd_taken = 1'b0;
        tick(); tick(); tick();
        check("disabled_lookups", {28'b0, stat_lookups}, 32'd0);
        check("disabled_mispred", {28'b0, stat_mispred}, 32'd0);
        enable = 1'b1;

        for (int i = 0; i < 20; i++) begin
            upd_en = (i < 17); upd_mispred = (i < 17);
            tick();
            if (i == 4) begin
                check("stats_lookups_5", {28'b0, stat_lookups}, 32'd5);
                check("stats_mispred_5", {28'b0, stat_mispred}, 32'd5);
            end
        end
        lookup_valid = 1'b0; upd_en = 1'b0; upd_mispred = 1'b0;
        check("stats_lookups_sat", {28'b0, stat_lookups}, 32'd15);
        check("stats_mispred_sat", {28'b0, stat_mispred}, 32'd15);

        // Train 0x40 again, then reset mid-cycle.
        upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        tick();
        upd_en = 1'b0; lookup_pc = 32'h40;
        #1;
        check_pred("pre_reset_trained", 1'b1, 32'h100);
        #2;
        arst_n = 1'b0;
        #1;
        check_pred("mid_reset", 1'b0, 32'h44);
        check("mid_reset_lookups", {28'b0, stat_lookups}, 32'd0);
        check("mid_reset_mispred", {28'b0, stat_mispred}, 32'd0);
        upd_en = 1'b1; lookup_valid = 1'b1;
        tick();
        check_pred("held_reset", 1'b0, 32'h44);
        upd_en = 1'b0; lookup_valid = 1'b0;
        arst_n = 1'b1;
        tick();
        check_pred("after_reset", 1'b0, 32'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
